alu_operand_sequencer: RTL



---
 rtl/alu_operand_sequencer_if.sv | 26 ++
 rtl/alu_operand_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer_if.sv
// ALU-side bus of the operand sequencer: registered operands and control
// code going out to the ALU, combinational result and flags coming back.
interface alu_operand_sequencer_if #(
  parameter int N = 3
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_result;
  logic         alu_z;
  logic         alu_n;
  logic         alu_v;
  logic         alu_c;

  // Sequencer side: drives operands/control, reads result/flags.
  modport master (
    output a, b, alu_ctrl,
    input  alu_result, alu_z, alu_n, alu_v, alu_c
  );

  // ALU side: reads operands/control, drives result/flags.
  modport slave (
    input  a, b, alu_ctrl,
    output alu_result, alu_z, alu_n, alu_v, alu_c
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: button-driven front end for the ALU lab datapath.
// Each accepted button press loads operand A, operand B, then the ALU control
// code from the switches; the next press returns to operand A entry. One cycle
// after the control code is loaded the ALU result and flags are captured.
// Optional feature: define ALU_SEQ_DEBOUNCE_EN to compile in the button
// debounce counter (DEBOUNCE_CYCLES stable cycles per level change).
module alu_operand_sequencer #(
  parameter int N               = 3,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            sw,
  input  logic                  btn_n,
  alu_operand_sequencer_if.master alu,
  output logic [N-1:0]          result_q,
  output logic [3:0]            flags_q,
  output logic [1:0]            step,
  output logic                  valid
);

  localparam logic [1:0] S_A   = 2'd0;
  localparam logic [1:0] S_B   = 2'd1;
  localparam logic [1:0] S_OP  = 2'd2;
  localparam logic [1:0] S_RUN = 2'd3;

  logic [3:0] sw_meta_reg;
  logic [3:0] sw_sync_reg;
  logic       btn_meta_reg;
  logic       btn_sync_reg;
  logic       level;           // conditioned button level (active-low)
  logic       level_prev_reg;
  logic       press_reg;       // one-cycle press event
  logic [1:0] state_reg;
  logic       capture_reg;     // high during the first cycle in S_RUN

  // Two-flop synchronizers for the asynchronous switches and button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta_reg  <= '0;
      sw_sync_reg  <= '0;
      btn_meta_reg <= 1'b1;
      btn_sync_reg <= 1'b1;
    end else begin
      sw_meta_reg  <= sw;
      sw_sync_reg  <= sw_meta_reg;
      btn_meta_reg <= btn_n;
      btn_sync_reg <= btn_meta_reg;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             level_reg;
  logic [CNT_W-1:0] db_cnt_reg;

  // Debounce: adopt the new level only after it has differed for
  // DEBOUNCE_CYCLES consecutive cycles; any return restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_reg  <= 1'b1;
      db_cnt_reg <= '0;
    end else if (btn_sync_reg != level_reg) begin
      if (db_cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_reg  <= btn_sync_reg;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end else begin
      db_cnt_reg <= '0;
    end
  end

  assign level = level_reg;
`else
  // No filter in this build: the synchronized button is the conditioned
  // level. The parameter term is constant false and only keeps the unused
  // debounce length visible to readers of this branch.
  assign level = btn_sync_reg | (DEBOUNCE_CYCLES < 0);
`endif

  // Falling-edge detector on the conditioned level: one pulse per press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_prev_reg <= 1'b1;
      press_reg      <= 1'b0;
    end else begin
      level_prev_reg <= level;
      press_reg      <= level_prev_reg & ~level;
    end
  end

  // Step FSM: load operands/control on presses, capture ALU output once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_A;
      capture_reg  <= 1'b0;
      alu.a        <= '0;
      alu.b        <= '0;
      alu.alu_ctrl <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      valid        <= 1'b0;
    end else begin
      capture_reg <= 1'b0;
      case (state_reg)
        S_A: begin
          if (press_reg) begin
            alu.a     <= sw_sync_reg[N-1:0];
            state_reg <= S_B;
          end
        end
        S_B: begin
          if (press_reg) begin
            alu.b     <= sw_sync_reg[N-1:0];
            state_reg <= S_OP;
          end
        end
        S_OP: begin
          if (press_reg) begin
            alu.alu_ctrl <= sw_sync_reg;
            capture_reg  <= 1'b1;
            state_reg    <= S_RUN;
          end
        end
        S_RUN: begin
          // The ALU has had a full cycle on the new operands by now.
          if (capture_reg) begin
            result_q <= alu.alu_result;
            flags_q  <= {alu.alu_z, alu.alu_n, alu.alu_v, alu.alu_c};
            valid    <= ~press_reg;
          end
          if (press_reg) begin
            valid     <= 1'b0;
            state_reg <= S_A;
          end
        end
        default: state_reg <= S_A;
      endcase
    end
  end

  assign step = state_reg;

endmodule
